// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with one idle cycle between grants and an
// optional hold-time limit that forces the owner off the resource.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; a pending request is picked at the next edge
// GRANT | grant_idx owns the resource until done, request drop or limit
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      ptr, ptr_nxt;
  logic [2:0]      idx_nxt;
  logic [CW-1:0]   hold_cnt, hold_cnt_nxt;
  logic            timeout_nxt;

  logic [15:0]     req_dbl;
  logic [7:0]      req_rot;
  logic [2:0]      pick_off;
  logic [2:0]      pick_idx;
  logic            owner_req;
  logic            hold_hit;
  logic            release_now;
  logic            forced;

  // Rotate so that the pointer position lands on bit 0, then take the
  // lowest set bit; adding the pointer back gives the absolute index.
  always_comb begin
    req_dbl  = {req, req};
    req_rot  = req_dbl[8'(ptr) +: 8];
    pick_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) pick_off = 3'(i);
    end
    pick_idx = ptr + pick_off;
  end

  always_comb begin
    owner_req   = req[grant_idx];
    hold_hit    = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD));
    release_now = done || !owner_req || hold_hit;
    forced      = hold_hit && !done && owner_req;
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    idx_nxt      = grant_idx;
    hold_cnt_nxt = hold_cnt;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (req != 8'd0) begin
          state_nxt    = GRANT;
          idx_nxt      = pick_idx;
          hold_cnt_nxt = CW'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt    = IDLE;
          ptr_nxt      = grant_idx + 3'd1;
          hold_cnt_nxt = '0;
          timeout_nxt  = forced;
        end else begin
          hold_cnt_nxt = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      grant_idx <= 3'd0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_idx <= idx_nxt;
      hold_cnt  <= hold_cnt_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Outputs decode straight from state so reset drops the grant immediately.
  always_comb begin
    busy  = (state == GRANT);
    grant = 8'd0;
    if (busy) grant = 8'd1 << grant_idx;
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4): round-robin order, hold limit,
// async reset and idle-gap behaviour, with hand-computed expectations.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .reset     (rst),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Structural invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    logic [7:0] dec;
    dec = 8'd1 << grant_idx;
    n_vec++;
    assert ($onehot0(grant)) else begin
      n_err++;
      $error("FAIL onehot0 observed=%h expected=at-most-one-bit", grant);
    end
    if (busy) begin
      n_vec++;
      assert (grant === dec) else begin
        n_err++;
        $error("FAIL grant_decode observed=%h expected=%h", grant, dec);
      end
    end
  end

  initial begin
    logic [7:0] e;
    rst  = 1'b0;
    req  = 8'd0;
    done = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_grant", grant, 8'h00);
    check("rst_idx", {5'd0, grant_idx}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_timeout", {7'd0, timeout}, 8'd0);
    tick();
    rst = 1'b0;

    // first grant one edge after reset release, lowest index wins from ptr 0
    req = 8'b1000_0001;
    tick();
    check("first_grant", grant, 8'h01);
    check("first_idx", {5'd0, grant_idx}, 8'd0);
    check("first_busy", {7'd0, busy}, 8'd1);
    done = 1'b1;
    tick();
    check("rel_grant", grant, 8'h00);
    check("rel_busy", {7'd0, busy}, 8'd0);
    check("rel_idx_hold", {5'd0, grant_idx}, 8'd0);
    done = 1'b0;
    req  = 8'd0;
    tick();
    check("idle_noreq", grant, 8'h00);
    check("idle_idx_hold", {5'd0, grant_idx}, 8'd0);
    req = 8'b1000_0001;
    tick();
    check("ptr_advanced", grant, 8'h80);
    check("ptr_adv_idx", {5'd0, grant_idx}, 8'd7);
    req = 8'd0;
    tick();
    check("drop_release", grant, 8'h00);

    // full rotation with wrap 7 -> 0
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      e = 8'd1 << (i % 8);
      tick();
      check("rr_grant", grant, e);
      check("rr_idx", {5'd0, grant_idx}, 8'(i % 8));
      done = 1'b1;
      tick();
      check("rr_gap", grant, 8'h00);
      check("rr_gap_busy", {7'd0, busy}, 8'd0);
      done = 1'b0;
    end

    // hold limit forces release, timeout pulses once, then regrant
    do_reset();
    req = 8'b0000_0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_grant", grant, 8'h04);
      check("hold_timeout", {7'd0, timeout}, 8'd0);
    end
    tick();
    check("forced_grant", grant, 8'h00);
    check("forced_timeout", {7'd0, timeout}, 8'd1);
    check("forced_idx", {5'd0, grant_idx}, 8'd2);
    tick();
    check("regrant", grant, 8'h04);
    check("regrant_timeout", {7'd0, timeout}, 8'd0);

    // done on the final hold cycle is a normal release
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold2_grant", grant, 8'h04);
    end
    done = 1'b1;
    tick();
    check("done_at_max_grant", grant, 8'h00);
    check("done_at_max_timeout", {7'd0, timeout}, 8'd0);
    done = 1'b0;
    req  = 8'd0;
    tick();
    check("post_timeout", {7'd0, timeout}, 8'd0);

    // async reset mid-grant
    do_reset();
    req = 8'b0010_0000;
    tick();
    check("own5_grant", grant, 8'h20);
    #2 rst = 1'b1;
    #1;
    check("async_grant", grant, 8'h00);
    check("async_idx", {5'd0, grant_idx}, 8'd0);
    check("async_busy", {7'd0, busy}, 8'd0);
    #2 rst = 1'b0;
    req = 8'b0010_0001;
    tick();
    check("post_rst_grant", grant, 8'h01);

    // non-owner request churn and done while idle
    do_reset();
    req = 8'b0000_1000;
    tick();
    check("own3_grant", grant, 8'h08);
    req = 8'b0100_1000;
    tick();
    check("churn_on", grant, 8'h08);
    req = 8'b0000_1000;
    tick();
    check("churn_off", grant, 8'h08);
    done = 1'b1;
    tick();
    check("own3_release", grant, 8'h00);
    req = 8'd0;
    tick();
    check("idle_done_grant", grant, 8'h00);
    check("idle_done_busy", {7'd0, busy}, 8'd0);
    done = 1'b0;
    tick();
    check("idle_quiet", grant, 8'h00);
    req = 8'b0000_1000;
    tick();
    check("own3_again", grant, 8'h08);
    req = 8'd0;
    tick();
    check("own3_drop", grant, 8'h00);
    check("own3_drop_timeout", {7'd0, timeout}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum consecutive cycles one owner may hold the grant; 0 disables the limit.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005 SHALL have port done  input  1  current owner releases the resource; ignored when no grant is active.
REQ-006 SHALL have port grant  output  8  one-hot grant, or all-zero when no grant is active.
REQ-007 SHALL have port grant_idx  output  3  binary index of the current or most recent owner.
REQ-008 SHALL have port busy  output  1  high while a grant is active.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse after a MAX_HOLD forced release.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (grant=0, busy=0) and GRANT (grant=one-hot, busy=1).
REQ-011 SHALL keep a 3-bit priority pointer ptr; the search order is ptr, ptr+1, ..., ptr+7 mod 8, wrapping 7->0.
REQ-012 IDLE with req != 0 at edge N: SHALL select the first set bit in search order and enter GRANT; grant and grant_idx are valid from cycle N+1 (latency 1).
REQ-013 IDLE with req == 0: SHALL remain in IDLE; grant stays 0 and grant_idx holds its value.
REQ-014 grant SHALL always equal the 3-to-8 decode of grant_idx while busy=1, and SHALL never have more than one bit set.
REQ-015 In GRANT, a release SHALL occur at the edge where any of these is sampled: done=1, req[grant_idx]=0, or the hold count reaches MAX_HOLD.
REQ-016 On release: SHALL return to IDLE, drive grant=0, and set ptr=grant_idx+1 mod 8 (owner 7 -> ptr 0).
REQ-017 There SHALL be at least one cycle with grant=0 between two grants, including back-to-back grants to the same requester.
REQ-018 Hold counter width SHALL be clog2(MAX_HOLD+1); it is 1 in the first GRANT cycle, increments each GRANT cycle, and clears on release.
REQ-019 On a forced release (count==MAX_HOLD with done=0 and req[grant_idx]=1): timeout SHALL be 1 for exactly the first IDLE cycle, else 0.
REQ-020 If done=1 coincides with count==MAX_HOLD: SHALL treat it as a normal release, with timeout=0.
REQ-021 With MAX_HOLD=0: SHALL never force a release and never assert timeout.
REQ-022 req changes on non-owner bits during GRANT SHALL have no effect on grant.
REQ-023 A requester that drops and re-raises req while IDLE SHALL be arbitrated only by the current ptr; there is no request memory.

Reset
REQ-024 On reset assertion: SHALL drive immediately, without waiting for clk, state=IDLE, grant=8'b0, grant_idx=3'd0, busy=0, timeout=0, ptr=0, hold count=0.
REQ-025 A reset asserted mid-grant SHALL drop grant in the same cycle; after release, requester 0 has top priority.
REQ-026 The first possible grant SHALL appear one edge after reset deasserts with req != 0.

Verification
REQ-027 After reset, req=8'b1000_0001 -> grant=8'b0000_0001, grant_idx=0, busy=1 one cycle later.
REQ-028 All req=8'hFF, done pulsed 1 cycle after each grant -> grants 0,1,...,7,0, each separated by one grant=0 cycle (wrap 7->0 checked).
REQ-029 MAX_HOLD=4, req=8'b0000_0100 held, done=0 -> grant=8'b0000_0100 for exactly 4 cycles, then grant=0 with timeout=1 for 1 cycle, then regrant to 2.
REQ-030 MAX_HOLD=4, done=1 on the 4th hold cycle -> release with timeout=0.
REQ-031 Owner 5 granted, then reset asserted between clock edges -> grant=0 and grant_idx=0 immediately; after release, req=8'b0010_0001 grants 0.
REQ-032 During a grant to 3, toggle req[6] and pulse done while IDLE -> no grant change and no spurious grant; checker asserts onehot0(grant) every cycle.
